// File: rtl/pwm_meter_if.sv
// Receive-side PWM meter bundle: the raw PWM line in, the per-frame
// measurement strobes and lock status out.
interface pwm_meter_if;
  logic       pwm;
  logic [3:0] duty;
  logic       valid;
  logic       err;
  logic       locked;

  modport master (output pwm, input duty, valid, err, locked);
  modport slave  (input pwm, output duty, valid, err, locked);
endinterface

// File: rtl/pwm_meter.sv
// Measures each PERIOD_CLKS-cycle PWM frame on an asynchronous line, reporting
// the high-clock count per frame and flagging frames of the wrong length.
module pwm_meter #(
  parameter int PERIOD_CLKS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pwm_meter_if.slave  bus
);

  localparam int CW = $clog2(2 * PERIOD_CLKS + 1);
  localparam logic [CW-1:0] PERIOD_CNT  = CW'(PERIOD_CLKS);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(2 * PERIOD_CLKS);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lvl_d_reg;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [CW-1:0]          hi_reg, hi_next;
  logic [3:0]             duty_reg, duty_next;
  logic                   valid_reg, valid_next;
  logic                   err_reg, err_next;
  logic                   locked_reg, locked_next;

  logic lvl;
  logic rise;
  logic timeout;

  assign lvl     = sync_reg[SYNC_STAGES-1];
  assign rise    = lvl & ~lvl_d_reg;
  assign timeout = (cnt_reg == TIMEOUT_CNT) && !rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_reg   <= '0;
      lvl_d_reg  <= 1'b0;
      state_reg  <= ACQUIRE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      duty_reg   <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], bus.pwm};
      lvl_d_reg  <= lvl;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      duty_reg   <= duty_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      locked_reg <= locked_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CW'(1);
    hi_next     = hi_reg + CW'(lvl);
    duty_next   = duty_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    locked_next = locked_reg;

    if (rise) begin
      // The edge cycle itself is high, so the new window starts at 1/1.
      cnt_next   = CW'(1);
      hi_next    = CW'(1);
      state_next = TRACK;
      if (state_reg == TRACK) begin
        if (cnt_reg == PERIOD_CNT) begin
          duty_next   = 4'(hi_reg);
          valid_next  = 1'b1;
          locked_next = 1'b1;
        end else begin
          err_next    = 1'b1;
          locked_next = 1'b0;
        end
      end
    end else if (timeout) begin
      // A static line is only a valid 0% or 100% frame if the whole window agrees.
      if (hi_reg == '0) begin
        duty_next   = 4'd0;
        valid_next  = 1'b1;
        locked_next = 1'b1;
      end else if (hi_reg == cnt_reg) begin
        duty_next   = 4'(PERIOD_CLKS);
        valid_next  = 1'b1;
        locked_next = 1'b1;
      end else begin
        err_next    = 1'b1;
        locked_next = 1'b0;
      end
      state_next = ACQUIRE;
      cnt_next   = '0;
      hi_next    = '0;
    end
  end

  assign bus.duty   = duty_reg;
  assign bus.valid  = valid_reg;
  assign bus.err    = err_reg;
  assign bus.locked = locked_reg;

endmodule
